button_press_gen: RTL
=====================

// Module: button_press_gen
// PURPOSE
//  Generates synthetic key-fob button presses on a single press line. It is the
//    driving end of the toggle-button interface.
//  A requested target level, or an explicit tap, becomes a clean press/release
//    waveform. Downstream toggle logic sees this waveform as one physical press.
//  Keeps a mirror of the downstream toggle level, so it issues exactly the
//    presses needed to reach the target.
//  Used by self-test and automation paths in the fob.
// PARAMETERS
//  CNT_W         8   width of the internal phase counter
//  PRESS_CYCLES  4   clocks the button line is held high per press; legal range 2..2**CNT_W-1
//  GAP_CYCLES    4   clocks the line is held low after each press; legal range 1..2**CNT_W-1
// PORTS
//  clk           in   1  single system clock; all logic on posedge
//  rst           in   1  synchronous, active-high reset
//  target_level  in   1  desired downstream toggle level
//  tap           in   1  1-clk request for one press, regardless of level
//  button        out  1  synthetic press line to the toggle FSM input
//  level         out  1  mirrored toggle level (the level the downstream block now holds)
//  busy          out  1  high while a press or its release gap is in progress
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - state=IDLE; button=0, level=0, busy=0, tap_pend=0, counter=0.
//   - Applies mid-press as well: the line drops to 0 on the next edge.
//  States:
//   - IDLE: button=0, busy=0.
//   - PRESS: button=1, busy=1.
//   - RELEASE: button=0, busy=1.
//  IDLE -> PRESS:
//   - Taken when (target_level != level) | tap | tap_pend is sampled at an edge.
//   - On that same edge: button<=1, busy<=1, level<=~level, counter<=PRESS_CYCLES-1,
//     tap_pend<=0.
//   - The level flip is aligned to the button rising edge. This matches the
//     downstream toggle, which changes output combinationally on press.
//  PRESS:
//   - Counter decrements each clk.
//   - At counter==0: button<=0, counter<=GAP_CYCLES-1, go to RELEASE.
//   - button is therefore high for exactly PRESS_CYCLES clocks.
//  RELEASE:
//   - Counter decrements each clk.
//   - At counter==0: busy<=0, go to IDLE.
//   - button is low for exactly GAP_CYCLES clocks before IDLE.
//  Request latency: request sampled at edge N -> button=1 from edge N onward.
//  Minimum press-to-press period is PRESS_CYCLES+GAP_CYCLES+1 clocks, because
//    at least one IDLE cycle separates presses.
//  Boundary conditions:
//   - tap while busy: sets tap_pend (one-deep; further taps while pending are
//     dropped). It is served on the first IDLE cycle.
//   - target_level changes while busy: ignored until IDLE, then compared
//     against level.
//   - tap and level mismatch in the same IDLE cycle: one press only. It clears
//     the tap, and the mismatch is re-evaluated at the next IDLE cycle.
//   - target_level toggling faster than the press period: only the value
//     sampled in IDLE matters; intermediate values produce no press.
//   - counter never wraps: it reloads on every state change.
// CONFIGURATION
//  PRESS_GEN_DONE_EN:
//   - Defined: adds output press_done (1 bit). It pulses high for exactly one
//     clk on the RELEASE->IDLE edge, i.e. the same edge busy falls. It resets to 0.
//   - Undefined: the port and its logic are absent; all other behaviour is identical.
// TESTING
//  - Reset check: rst=1 for 2 clks with tap=1, target_level=1 -> button=0, level=0,
//    busy=0 throughout reset.
//  - Single press (defaults): target_level 0->1 in IDLE -> button high 4 clks, low
//    4 clks; level=1 from the press edge; busy high 8 clks.
//  - Tap in IDLE with target_level=level=0 -> one press; level=1; next IDLE sees a
//    mismatch -> second press; level=0.
//  - Tap pending: tap during PRESS cycle 2 -> a second press starts exactly 1 IDLE
//    clk after the first gap ends. Two more taps during the same press -> still
//    only one extra press.
//  - Mid-press reset: rst at PRESS cycle 3 -> button=0, busy=0, level=0 next edge;
//    no resumed press.
//  - Closed loop: connect button to the toggle FSM. Drive target_level 0->1->0->1
//    with 20-clk spacing -> FSM output equals level at every clk.
//  - With PRESS_GEN_DONE_EN defined: press_done high exactly 1 clk per press.

Source files
------------

// File: rtl/button_press_if.sv
// Press-line bundle between the synthetic button generator and the toggle logic it drives.
// PRESS_GEN_DONE_EN adds the one-clock press_done strobe.
interface button_press_if;
    logic target_level;
    logic tap;
    logic button;
    logic level;
    logic busy;
`ifdef PRESS_GEN_DONE_EN
    logic press_done;
`endif

    modport master (
        input  target_level,
        input  tap,
        output button,
        output level,
        output busy
`ifdef PRESS_GEN_DONE_EN
        , output press_done
`endif
    );

    modport slave (
        output target_level,
        output tap,
        input  button,
        input  level,
        input  busy
`ifdef PRESS_GEN_DONE_EN
        , input press_done
`endif
    );
endinterface

// File: rtl/button_press_gen.sv
// Turns a target toggle level or a tap into clean press/release waveforms on one line.
// Optional PRESS_GEN_DONE_EN adds a one-clock press_done strobe when each release gap ends.
module button_press_gen #(
    parameter int CNT_W        = 8,
    parameter int PRESS_CYCLES = 4,
    parameter int GAP_CYCLES   = 4
) (
    input  logic          clk,
    input  logic          rst,
    button_press_if.master bus
);
    // state   | meaning
    // IDLE    | line low, waiting for a mismatch, tap or pending tap
    // PRESS   | line high for PRESS_CYCLES clocks
    // RELEASE | line low for GAP_CYCLES clocks before the next request is accepted
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             tap_pend_q, tap_pend_d;
    logic             button_o, busy_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= CNT_ZERO;
            level_q    <= 1'b0;
            tap_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            tap_pend_q <= tap_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        level_d    = level_q;
        tap_pend_d = tap_pend_q;
        case (state_q)
            IDLE: begin
                // One press serves both a tap and a mismatch; any leftover mismatch is seen next IDLE.
                if ((bus.target_level != level_q) || bus.tap || tap_pend_q) begin
                    state_d    = PRESS;
                    level_d    = ~level_q;
                    cnt_d      = PRESS_LOAD;
                    tap_pend_d = 1'b0;
                end
            end
            PRESS: begin
                tap_pend_d = tap_pend_q | bus.tap;
                if (cnt_q == CNT_ZERO) begin
                    state_d = RELEASE;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RELEASE: begin
                tap_pend_d = tap_pend_q | bus.tap;
                if (cnt_q == CNT_ZERO) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    always_comb begin
        button_o = 1'b0;
        busy_o   = 1'b0;
        case (state_q)
            PRESS: begin
                button_o = 1'b1;
                busy_o   = 1'b1;
            end
            RELEASE: begin
                busy_o = 1'b1;
            end
            default: begin
                button_o = 1'b0;
                busy_o   = 1'b0;
            end
        endcase
    end

    assign bus.button = button_o;
    assign bus.busy   = busy_o;
    assign bus.level  = level_q;

`ifdef PRESS_GEN_DONE_EN
    logic press_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            press_done_q <= 1'b0;
        end else begin
            press_done_q <= (state_q == RELEASE) && (cnt_q == CNT_ZERO);
        end
    end

    assign bus.press_done = press_done_q;
`endif
endmodule
